// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that shares one 8N1 UART TX line and
// one baud generator between NUM_REQ byte requesters.
// Optional even parity bit after the data bits: define TX_PARITY_EN.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          baud_tick,
  output logic                          baud_en,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          done
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned SW = 1;

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_START, S_DATA, S_PAR, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]           bit_idx_q, bit_idx_d;
  logic [SW-1:0]           stop_cnt_q, stop_cnt_d;
  logic [NUM_REQ-1:0]      grant_d;
  logic                    baud_en_d, tx_d, busy_d, done_d;
  logic [PW-1:0]           owner_d;
  logic                    win_found;
  logic [PW-1:0]           win_idx;
  logic [PW-1:0]           cand;
  logic [DATA_WIDTH-1:0]   win_byte;
`ifdef TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  // Round-robin pick: first pending request above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_byte = data_in[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next-state and next-output logic; the grant cycle itself ignores baud_tick.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    grant_d    = '0;
    baud_en_d  = baud_en;
    tx_d       = tx;
    busy_d     = busy;
    owner_d    = owner;
    done_d     = 1'b0;
`ifdef TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (win_found) begin
          grant_d   = NUM_REQ'(1) << win_idx;
          shreg_d   = win_byte;
          owner_d   = win_idx;
          ptr_d     = win_idx;
          baud_en_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_SYNC;
`ifdef TX_PARITY_EN
          parity_d  = ^win_byte;
`endif
        end
      end
      S_SYNC: begin
        if (baud_tick && (grant == '0)) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_tick) begin
          state_d   = S_DATA;
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == BW'(DATA_WIDTH-1)) begin
`ifdef TX_PARITY_EN
            state_d    = S_PAR;
            tx_d       = parity_q;
`else
            state_d    = S_STOP;
            tx_d       = 1'b1;
            stop_cnt_d = '0;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
      end
`ifdef TX_PARITY_EN
      S_PAR: begin
        if (baud_tick) begin
          state_d    = S_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = '0;
        end
      end
`endif
      S_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == SW'(STOP_BITS-1)) begin
            state_d   = S_IDLE;
            baud_en_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(NUM_REQ-1);
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= '0;
      grant      <= '0;
      baud_en    <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      owner      <= '0;
      done       <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      grant      <= grant_d;
      baud_en    <= baud_en_d;
      tx         <= tx_d;
      busy       <= busy_d;
      owner      <= owner_d;
      done       <= done_d;
`ifdef TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: scoreboard of expected (owner, byte) pairs,
// frames decoded from tx by sampling mid bit period.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned SB = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  grant;
  logic        baud_tick;
  logic        baud_en;
  logic        tx;
  logic        busy;
  logic [1:0]  owner;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] own;
    logic [7:0] dat;
  } exp_t;
  exp_t sb[$];

  uart_tx_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .STOP_BITS(SB)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .grant(grant),
    .baud_tick(baud_tick), .baud_en(baud_en), .tx(tx), .busy(busy),
    .owner(owner), .done(done)
  );

  always #5 clk = ~clk;

  // Free-running bit-period pulse, one cycle every 4 clocks.
  initial begin
    int ph;
    ph = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      baud_tick = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_grant(output bit to, output logic [3:0] g, output logic [1:0] o,
                            output int waits, output bit saw_done);
    to = 1'b1; g = '0; o = '0; waits = 0; saw_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      waits++;
      if (done === 1'b1) saw_done = 1'b1;
      if (grant !== 4'b0000) begin
        g = grant; o = owner; to = 1'b0;
        break;
      end
    end
  endtask

  // Decode one frame starting on the cycle after the grant.
  task automatic capture_bits(output bit to, output logic g_after, output logic [7:0] d,
                              output logic p, output bit fmt_ok, output bit done_ok);
    to = 1'b1; g_after = 1'b0; d = '0; p = 1'b0; fmt_ok = 1'b1; done_ok = 1'b1;
    step();
    g_after = |grant;
    for (int i = 0; i < 20; i++) begin
      if (tx === 1'b0) begin to = 1'b0; break; end
      step();
    end
    if (to) return;
    step(2);
    if (tx !== 1'b0) fmt_ok = 1'b0;
    for (int b = 0; b < 8; b++) begin step(4); d[b] = tx; end
`ifdef TX_PARITY_EN
    step(4); p = tx;
`endif
    for (int s = 0; s < int'(SB); s++) begin step(4); if (tx !== 1'b1) fmt_ok = 1'b0; end
    step(1);
    if (done !== 1'b0 || baud_en !== 1'b1) done_ok = 1'b0;
    step(1);
    if (done !== 1'b1 || baud_en !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) done_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; data_in = '0;
    step(3);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++; if (baud_en !== 1'b0) begin n_fail++; $display("FAIL reset_baud_en: got %b want 0", baud_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tx !== 1'b1 || baud_en !== 1'b0 || busy !== 1'b0 || grant !== 4'b0000 || done !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_outputs: %0d bad cycles, want 0", bad); end
  endtask

  task automatic test_single();
    bit to, sd, fmt, dn; logic [3:0] g; logic [1:0] o; int w; logic ga, p; logic [7:0] d; exp_t e;
    data_in = '0; data_in[23:16] = 8'hA5; req = 4'b0100;
    sb.push_back('{own: 2'd2, dat: 8'hA5});
    wait_grant(to, g, o, w, sd);
    req = '0;
    n_checks++; if (to) begin n_fail++; $display("FAIL single_grant_timeout: no grant, want grant"); end
    n_checks++; if (g !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", g); end
    e = sb.pop_front();
    n_checks++; if (o !== e.own) begin n_fail++; $display("FAIL single_owner: got %0d want %0d", o, e.own); end
    capture_bits(to, ga, d, p, fmt, dn);
    n_checks++; if (to) begin n_fail++; $display("FAIL single_start_timeout: no start bit"); end
    n_checks++; if (ga !== 1'b0) begin n_fail++; $display("FAIL single_grant_pulse: got %b want 0", ga); end
    n_checks++; if (d !== e.dat) begin n_fail++; $display("FAIL single_byte: got %h want %h", d, e.dat); end
    n_checks++; if (!fmt) begin n_fail++; $display("FAIL single_framing: start/stop bits wrong"); end
    n_checks++; if (!dn) begin n_fail++; $display("FAIL single_done: done/baud_en timing wrong"); end
`ifdef TX_PARITY_EN
    n_checks++; if (p !== ^e.dat) begin n_fail++; $display("FAIL single_parity: got %b want %b", p, ^e.dat); end
`endif
  endtask

  task automatic test_back_to_back();
    bit to, sd, fmt, dn; logic [3:0] g; logic [1:0] o; int w; logic ga, p; logic [7:0] d; exp_t e;
    logic [3:0] g_exp;
    reset = 1'b1; step(2); reset = 1'b0;
    data_in = {8'h04, 8'h03, 8'h02, 8'h01};
    for (int f = 0; f < 5; f++) sb.push_back('{own: 2'(f % 4), dat: 8'((f % 4) + 1)});
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_grant(to, g, o, w, sd);
      if (f == 4) req = '0;
      e = sb.pop_front();
      g_exp = 4'b0001 << e.own;
      n_checks++; if (g !== g_exp) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %b want %b", f, g, g_exp); end
      n_checks++; if (o !== e.own) begin n_fail++; $display("FAIL b2b_owner[%0d]: got %0d want %0d", f, o, e.own); end
      if (f > 0) begin
        n_checks++; if (w !== 1) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d cycles want 1", f, w); end
      end
      capture_bits(to, ga, d, p, fmt, dn);
      n_checks++; if (d !== e.dat) begin n_fail++; $display("FAIL b2b_byte[%0d]: got %h want %h", f, d, e.dat); end
      n_checks++; if (!fmt || !dn || to) begin n_fail++; $display("FAIL b2b_frame[%0d]: fmt=%b done=%b timeout=%b", f, fmt, dn, to); end
    end
  endtask

  task automatic test_reset_mid();
    bit to, sd, fmt, dn; logic [3:0] g; logic [1:0] o; int w; logic ga, p; logic [7:0] d; exp_t e;
    bit started;
    data_in = '0; data_in[7:0] = 8'h81; data_in[15:8] = 8'h5A;
    req = 4'b0010;
    wait_grant(to, g, o, w, sd);
    req = 4'b0011;
    n_checks++; if (o !== 2'd1 || to) begin n_fail++; $display("FAIL rstmid_first_owner: got %0d want 1", o); end
    started = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx === 1'b0) begin started = 1'b1; break; end
    end
    n_checks++; if (!started) begin n_fail++; $display("FAIL rstmid_start_timeout: no start bit"); end
    step(2 + 4*3);
    reset = 1'b1;
    step();
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    n_checks++; if (busy !== 1'b0 || baud_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_baud: got %b%b want 00", busy, baud_en); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done); end
    n_checks++; if (owner !== 2'd0) begin n_fail++; $display("FAIL rstmid_owner: got %0d want 0", owner); end
    reset = 1'b0;
    sb.push_back('{own: 2'd0, dat: 8'h81});
    sb.push_back('{own: 2'd1, dat: 8'h5A});
    wait_grant(to, g, o, w, sd);
    req = 4'b0010;
    e = sb.pop_front();
    n_checks++; if (sd) begin n_fail++; $display("FAIL rstmid_spurious_done: done seen after reset"); end
    n_checks++; if (g !== 4'b0001 || o !== e.own) begin n_fail++; $display("FAIL rstmid_priority: got grant %b owner %0d want 0001/%0d", g, o, e.own); end
    capture_bits(to, ga, d, p, fmt, dn);
    n_checks++; if (d !== e.dat || !fmt || !dn) begin n_fail++; $display("FAIL rstmid_frame0: got %h want %h", d, e.dat); end
    wait_grant(to, g, o, w, sd);
    req = '0;
    e = sb.pop_front();
    n_checks++; if (o !== e.own || to) begin n_fail++; $display("FAIL rstmid_owner1: got %0d want %0d", o, e.own); end
    capture_bits(to, ga, d, p, fmt, dn);
    n_checks++; if (d !== e.dat || !fmt || !dn) begin n_fail++; $display("FAIL rstmid_frame1: got %h want %h", d, e.dat); end
  endtask

  task automatic test_data_change();
    bit to, sd, fmt, dn; logic [3:0] g; logic [1:0] o; int w; logic ga, p; logic [7:0] d; exp_t e;
    data_in = '0; data_in[7:0] = 8'h3C; req = 4'b0001;
    sb.push_back('{own: 2'd0, dat: 8'h3C});
    wait_grant(to, g, o, w, sd);
    req = '0; data_in[7:0] = 8'hFF;
    e = sb.pop_front();
    n_checks++; if (o !== e.own || to) begin n_fail++; $display("FAIL chg_owner: got %0d want %0d", o, e.own); end
    capture_bits(to, ga, d, p, fmt, dn);
    n_checks++; if (d !== e.dat) begin n_fail++; $display("FAIL chg_byte: got %h want %h", d, e.dat); end
    n_checks++; if (!fmt || !dn || to) begin n_fail++; $display("FAIL chg_frame: fmt=%b done=%b timeout=%b", fmt, dn, to); end
    step(8);
    n_checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_fail++; $display("FAIL chg_no_regrant: busy=%b grant=%b want 0/0000", busy, grant); end
  endtask

`ifdef TX_PARITY_EN
  task automatic test_parity();
    bit to, sd, fmt, dn; logic [3:0] g; logic [1:0] o; int w; logic ga, p; logic [7:0] d; exp_t e;
    logic [7:0] bytes [2];
    bytes[0] = 8'h07; bytes[1] = 8'h03;
    for (int k = 0; k < 2; k++) begin
      data_in = '0; data_in[31:24] = bytes[k]; req = 4'b1000;
      sb.push_back('{own: 2'd3, dat: bytes[k]});
      wait_grant(to, g, o, w, sd);
      req = '0;
      e = sb.pop_front();
      capture_bits(to, ga, d, p, fmt, dn);
      n_checks++; if (d !== e.dat) begin n_fail++; $display("FAIL par_byte[%0d]: got %h want %h", k, d, e.dat); end
      n_checks++; if (p !== ^e.dat) begin n_fail++; $display("FAIL par_bit[%0d]: got %b want %b", k, p, ^e.dat); end
      n_checks++; if (!fmt || !dn || to) begin n_fail++; $display("FAIL par_frame[%0d]: fmt=%b done=%b timeout=%b", k, fmt, dn, to); end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; req = '0; data_in = '0;
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_data_change();
`ifdef TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
